// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and the
// majority-of-3 helper used by the bit samplers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_PARITY  = 3'd3,
    ST_STOP    = 3'd4,
    ST_RECOVER = 3'd5
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; the reset value
// is chosen by the user so idle-high lines come out of reset idle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      meta_q <= RST_VAL;
      o_q    <= RST_VAL;
    end else begin
      meta_q <= i_d;
      o_q    <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// Oversampled UART receiver: one frame per character with majority-vote bit
// sampling, parity/framing error flags and break detection.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int NB_DATA    = 8,
  parameter int NB_STOP    = 1,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_s_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_dout,
  output logic               o_rx_done_tick,
  output logic               o_parity_err,
  output logic               o_frame_err,
  output logic               o_break
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(NB_DATA + 1);

  localparam logic [CW-1:0] CNT_MID   = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] CNT_S0    = CW'(OVERSAMPLE - 3);
  localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(NB_DATA - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(NB_STOP - 1);
  localparam logic          PAR_MODE  = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  logic               rx_s;
  rx_state_e          state_q;
  logic [CW-1:0]      cnt_q;
  logic [BW-1:0]      bit_q;
  logic [NB_DATA-1:0] data_q;
  logic [1:0]         vote_q;
  logic               par_q;
  logic               perr_q;
  logic               ferr_q;

  logic bit_v;
  logic ferr_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  // Third vote is the live sample on the tick that closes the bit.
  assign bit_v  = maj3(vote_q[1], vote_q[0], rx_s);
  assign ferr_d = ferr_q | ~bit_v;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      bit_q          <= '0;
      data_q         <= '0;
      vote_q         <= '0;
      par_q          <= 1'b0;
      perr_q         <= 1'b0;
      ferr_q         <= 1'b0;
      o_dout         <= '0;
      o_rx_done_tick <= 1'b0;
      o_parity_err   <= 1'b0;
      o_frame_err    <= 1'b0;
      o_break        <= 1'b0;
    end else begin
      o_rx_done_tick <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_q <= ST_START;
            cnt_q   <= '0;
          end
        end
        ST_START: begin
          if (i_s_tick) begin
            if (cnt_q == CNT_MID) begin
              cnt_q <= '0;
              if (rx_s) begin
                state_q <= ST_IDLE;
              end else begin
                state_q <= ST_DATA;
                bit_q   <= '0;
                par_q   <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_DATA, ST_PARITY, ST_STOP: begin
          if (i_s_tick) begin
            if (cnt_q >= CNT_S0 && cnt_q != CNT_LAST)
              vote_q <= {vote_q[0], rx_s};
            if (cnt_q != CNT_LAST) begin
              cnt_q <= cnt_q + 1'b1;
            end else begin
              cnt_q <= '0;
              if (state_q == ST_DATA) begin
                data_q <= {bit_v, data_q[NB_DATA-1:1]};
                if (bit_q == DATA_LAST) begin
                  bit_q   <= '0;
                  state_q <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                end else begin
                  bit_q <= bit_q + 1'b1;
                end
              end else if (state_q == ST_PARITY) begin
                par_q   <= bit_v;
                perr_q  <= ((^data_q) ^ bit_v) != PAR_MODE;
                state_q <= ST_STOP;
              end else if (bit_q == STOP_LAST) begin
                o_dout         <= data_q;
                o_parity_err   <= perr_q;
                o_frame_err    <= ferr_d;
                o_break        <= ferr_d && (data_q == '0) && ((PARITY_EN == 0) || !par_q);
                o_rx_done_tick <= 1'b1;
                state_q        <= bit_v ? ST_IDLE : ST_RECOVER;
              end else begin
                bit_q  <= bit_q + 1'b1;
                ferr_q <= ferr_d;
              end
            end
          end
        end
        ST_RECOVER: begin
          if (rx_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Randomised scoreboard bench for uart_rx_frame (8 data bits, even parity,
// two stop bits, 16x oversampling).
module tb_uart_rx_frame;

  localparam int NB_DATA = 8;
  localparam int OS      = 16;
  localparam int NELEM   = 1 + NB_DATA + 1 + 2;
  localparam int FULL    = NELEM * OS;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       br;
  } exp_t;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_s_tick = 1'b0;
  logic       i_rx = 1'b1;
  logic [7:0] o_dout;
  logic       o_rx_done_tick;
  logic       o_parity_err;
  logic       o_frame_err;
  logic       o_break;

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  exp_t hold = '{8'h00, 1'b0, 1'b0, 1'b0};
  logic rst_d = 1'b1;
  logic done_d = 1'b0;

  uart_rx_frame #(
    .NB_DATA(NB_DATA), .NB_STOP(2), .OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_s_tick       (i_s_tick),
    .i_rx           (i_rx),
    .o_dout         (o_dout),
    .o_rx_done_tick (o_rx_done_tick),
    .o_parity_err   (o_parity_err),
    .o_frame_err    (o_frame_err),
    .o_break        (o_break)
  );

  always #5 i_clk = ~i_clk;

  // Monitor: pops expectations on each done pulse, otherwise outputs must hold.
  always @(negedge i_clk) begin
    exp_t e;
    if (rst_d) hold = '{8'h00, 1'b0, 1'b0, 1'b0};
    if (o_rx_done_tick === 1'b1) begin
      checks++;
      if (done_d) begin
        errors++;
        $display("FAIL done_width: done high two cycles in a row");
      end
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: dout=%h pe=%b fe=%b br=%b", o_dout, o_parity_err, o_frame_err, o_break);
      end else begin
        e = sbq.pop_front();
        if (o_dout !== e.d || o_parity_err !== e.pe || o_frame_err !== e.fe || o_break !== e.br) begin
          errors++;
          $display("FAIL frame: got dout=%h pe=%b fe=%b br=%b exp dout=%h pe=%b fe=%b br=%b",
                   o_dout, o_parity_err, o_frame_err, o_break, e.d, e.pe, e.fe, e.br);
        end
        hold = e;
      end
    end else begin
      checks++;
      if (o_rx_done_tick !== 1'b0 || o_dout !== hold.d || o_parity_err !== hold.pe ||
          o_frame_err !== hold.fe || o_break !== hold.br) begin
        errors++;
        $display("FAIL hold: got done=%b dout=%h pe=%b fe=%b br=%b exp dout=%h pe=%b fe=%b br=%b",
                 o_rx_done_tick, o_dout, o_parity_err, o_frame_err, o_break,
                 hold.d, hold.pe, hold.fe, hold.br);
      end
    end
    done_d = (o_rx_done_tick === 1'b1);
    rst_d  = i_reset;
  end

  // One oversample period: line value set, then a single tick three clocks later.
  task automatic step(input logic v);
    i_rx = v;
    repeat (3) begin @(posedge i_clk); #1; end
    i_s_tick = 1'b1;
    @(posedge i_clk); #1;
    i_s_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1);
  endtask

  // Plays the first nticks of a frame; a whole frame pushes its expected result.
  task automatic play(input logic [7:0] d, input logic pbit, input logic s1, input logic s2,
                      input int gbit, input int goff, input int nticks);
    logic el [NELEM];
    logic v;
    exp_t e;
    el[0] = 1'b0;
    for (int i = 0; i < NB_DATA; i++) el[1+i] = d[i];
    el[9]  = pbit;
    el[10] = s1;
    el[11] = s2;
    if (nticks == FULL) begin
      e.d  = d;
      e.pe = ((^d) ^ pbit) != 1'b0;
      e.fe = !s1 || !s2;
      e.br = e.fe && d == 8'h00 && !pbit;
      sbq.push_back(e);
    end
    for (int k = 0; k < nticks; k++) begin
      v = el[k / OS];
      if (gbit >= 0 && k / OS == gbit + 1 && k % OS == goff) v = ~v;
      step(v);
    end
  endtask

  task automatic expect_drained(input string name);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected frame(s) never completed", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic frame(input logic [7:0] d, input logic pbit, input logic s1, input logic s2,
                       input int gbit, input int goff, input string name);
    play(d, pbit, s1, s2, gbit, goff, FULL);
    idle(20);
    expect_drained(name);
  endtask

  initial begin
    logic [7:0] d;
    logic       p, s1, s2;
    int         gb, go;

    repeat (5) @(posedge i_clk);
    #1 i_reset = 1'b0;
    idle(10);

    frame(8'hA5, 1'b0, 1'b1, 1'b1, -1, 0, "a5_good");
    frame(8'hA5, 1'b1, 1'b1, 1'b1, -1, 0, "a5_parity");

    repeat (4) step(1'b0);
    idle(30);
    frame(8'h3C, 1'b0, 1'b1, 1'b1, -1, 0, "false_start_then_3c");

    frame(8'h5A, 1'b0, 1'b1, 1'b1, 3, 6, "glitch_5a");

    sbq.push_back('{8'h00, 1'b0, 1'b1, 1'b1});
    repeat (12 * OS) step(1'b0);
    expect_drained("break");
    idle(20);
    frame(8'h81, 1'b0, 1'b1, 1'b1, -1, 0, "after_break_81");

    frame(8'h33, 1'b0, 1'b1, 1'b0, -1, 0, "stop2_low");

    play(8'hC7, 1'b1, 1'b1, 1'b1, -1, 0, 5 * OS + 8);
    i_rx = 1'b1;
    i_reset = 1'b1;
    repeat (3) begin @(posedge i_clk); #1; end
    i_reset = 1'b0;
    idle(30);
    expect_drained("reset_mid_frame");

    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      p  = ^d;
      if ($urandom_range(0, 3) == 0) p = ~p;
      s1 = ($urandom_range(0, 7) != 0);
      s2 = ($urandom_range(0, 7) != 0);
      gb = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 7));
      go = int'($urandom_range(0, OS - 1));
      frame(d, p, s1, s2, gb, go, "random");
    end

    repeat (4) @(posedge i_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver that recovers one serial frame per character from an oversampled line, with configurable data width, optional parity, one or two stop bits and selectable oversampling ratio. Adds input synchronisation, false-start rejection, 3-sample majority voting, parity/framing error flags and break detection. Sits between the pin and the RX FIFO/interface logic and is driven by the shared baud-rate tick generator.

## Interface

- NB_DATA, 8, data bits per frame, 5..9, LSB first
- NB_STOP, 1, stop bits, 1 or 2
- OVERSAMPLE, 16, ticks per bit, even, >= 8
- PARITY_EN, 0, 1 = parity bit present after data
- PARITY_ODD, 0, 1 = odd parity, 0 = even (ignored if PARITY_EN=0)

- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_s_tick  in  1  oversample tick, one i_clk wide, OVERSAMPLE per bit time
- i_rx  in  1  asynchronous serial line, idle high
- o_dout  out  NB_DATA  last received data word
- o_rx_done_tick  out  1  one-cycle pulse, frame complete
- o_parity_err  out  1  parity mismatch on last frame
- o_frame_err  out  1  any stop bit sampled low on last frame
- o_break  out  1  last frame was a break (all-zero data, parity and stop bits low)

## Operation

- i_rx passes a 2-FF synchroniser (reset value 1); all logic uses synchronised rx_s.
- States: IDLE, START, DATA, PARITY, STOP, RECOVER.
- IDLE: rx_s==0 -> START, tick counter cleared. Ticks ignored.
- START: on tick, counter increments; at count OVERSAMPLE/2-1 rx_s sampled: 1 -> IDLE (false start, no pulse); 0 -> DATA, counters cleared.
- DATA/PARITY/STOP: counter 0..OVERSAMPLE-1 per bit; rx_s sampled on ticks with counter = OVERSAMPLE-3, -2, -1; bit value = majority of 3. On tick with counter OVERSAMPLE-1 the bit completes and counter wraps to 0.
- DATA: bits shifted in from MSB side (LSB first on line); after NB_DATA bits -> PARITY if PARITY_EN else STOP.
- PARITY: error if XOR(data, parity bit) != PARITY_ODD.
- STOP: NB_STOP bits; any bit 0 sets frame error. After last stop bit: outputs update, done pulse; -> IDLE if last stop bit 1, else RECOVER.
- RECOVER: wait until rx_s==1, then IDLE; prevents break/stuck-low retriggering.
- o_dout, o_parity_err, o_frame_err, o_break update together with the done pulse and hold until the next done; never change mid-frame.
- o_break = frame error AND all data bits 0 AND (parity bit 0 or PARITY_EN=0).
- Reset mid-frame: state -> IDLE, all outputs 0, no done pulse, partial data discarded.
- i_s_tick asserted in the same cycle as a state change is consumed by the new state only if the transition was itself tick-driven; IDLE->START transition does not consume a tick.

## Timing

- Reset value of every output: 0.
- i_rx to rx_s: 2 i_clk.
- o_rx_done_tick and flag/data update: registered, asserted the i_clk after the tick completing the last stop bit; exactly 1 cycle wide.
- Frame length (ticks from start detect to done): OVERSAMPLE/2 + OVERSAMPLE*(NB_DATA+PARITY_EN+NB_STOP), ±1 cycle.
- Counters sized $clog2(OVERSAMPLE) and $clog2(NB_DATA+1); no wrap beyond terminal values.

## Structure

- Shared package uart_pkg: state encoding localparams, parity-mode constants, helper function for majority-of-3.
- One sub-module: sync_2ff (parametrised reset value), reusable by the TX/flow-control blocks.
- Majority sampler and parity check stay inline in uart_rx_frame.

## Test plan

- NB_DATA=8, OVERSAMPLE=16, PARITY_EN=1 even, send 0xA5 with parity 0, stop 1 -> o_dout=0xA5, one done pulse, all error flags 0.
- Same config, 0xA5 with parity bit 1 -> o_dout=0xA5, o_parity_err=1, o_frame_err=0.
- Line low for 4 ticks then high -> no done pulse, FSM back in IDLE; following valid 0x3C received correctly.
- Single-tick glitch inverting bit 3 at counter 14 of frame 0x5A -> o_dout=0x5A (majority vote).
- Line held low 12 bit-times -> one done with o_dout=0x00, o_frame_err=1, o_break=1; no further done until line high, then 0x81 received cleanly.
- NB_STOP=2, second stop bit 0 -> o_frame_err=1; i_reset during bit 4 of next frame -> outputs 0, no done pulse.
